// File: rtl/tone_detector.sv
// tone_detector: square-wave half-period measurement and 8-note classification with lock/silence tracking
module tone_detector #(
  parameter int CNT_W = 14,
  parameter int TOL = 16,
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT = 8192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tone_in,
  output logic [2:0]       note_idx,
  output logic             note_valid,
  output logic             note_strobe,
  output logic             silent,
  output logic [CNT_W-1:0] half_period
);
  localparam int MC_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] TOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOLV = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TBL [8] = '{CNT_W'(1916), CNT_W'(2033), CNT_W'(2273), CNT_W'(2565),
                                          CNT_W'(2874), CNT_W'(3049), CNT_W'(3425), CNT_W'(3847)};
  typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} state_t;
  state_t state, state_n;
  logic s1, s2, s3, edg, hit, strobe_n;
  logic [CNT_W-1:0] cnt, diff;
  logic [2:0] cand, cand_n, idx_n, hit_idx;
  logic [MC_W-1:0] mc, mc_n;
  assign edg = (s2 ^ s3) & enable;
  assign silent = state == SILENT;
  assign note_valid = state == LOCKED;
  // lowest matching table index wins when tolerance windows overlap
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    diff = '0;
    for (int k = 0; k < 8; k++) begin
      diff = cnt > TBL[k] ? cnt - TBL[k] : TBL[k] - cnt;
      if (!hit && diff <= TOLV) begin
        hit = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end
  always_comb begin
    state_n = state;
    cand_n = cand;
    mc_n = mc;
    idx_n = note_idx;
    strobe_n = 1'b0;
    if (!enable) state_n = SILENT;
    else if (edg) begin
      case (state)
        SILENT: begin
          state_n = ACQUIRE;
          mc_n = '0;
        end
        ACQUIRE: begin
          cand_n = hit ? hit_idx : cand;
          mc_n = !hit ? '0 : (hit_idx == cand ? mc + 1'b1 : MC_W'(1));
          if (mc_n >= MC_W'(STABLE_CNT)) begin
            state_n = LOCKED;
            idx_n = cand_n;
            strobe_n = 1'b1;
          end
        end
        default: if (!(hit && hit_idx == note_idx)) begin
          state_n = ACQUIRE;
          cand_n = hit ? hit_idx : cand;
          mc_n = hit ? MC_W'(1) : '0;
        end
      endcase
    end else if (cnt == TOUT) state_n = SILENT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, s3} <= '0;
      cnt <= '0;
      half_period <= '0;
      state <= SILENT;
      cand <= '0;
      mc <= '0;
      note_idx <= '0;
      note_strobe <= 1'b0;
    end else begin
      {s1, s2, s3} <= {tone_in, s1, s2};
      cnt <= edg ? CNT_W'(1) : (cnt == TOUT ? cnt : cnt + 1'b1);
      if (edg) half_period <= cnt;
      state <= state_n;
      cand <= cand_n;
      mc <= mc_n;
      note_idx <= idx_n;
      note_strobe <= strobe_n;
    end
  end
endmodule
